// File: rtl/imm_dec_ctrl.sv
// Decode-stage skid buffer that pre-decodes the immediate-extend opcode.
// Optional ID_ILLEGAL_CHK_EN adds a registered illegal-instruction flag.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef IMM_GEN_OP_WIDTH
`define IMM_GEN_OP_WIDTH 3
`endif
`ifndef IMM_GEN_I
`define IMM_GEN_I 3'b000
`endif
`ifndef IMM_GEN_S
`define IMM_GEN_S 3'b001
`endif
`ifndef IMM_GEN_B
`define IMM_GEN_B 3'b010
`endif
`ifndef IMM_GEN_U
`define IMM_GEN_U 3'b011
`endif
`ifndef IMM_GEN_J
`define IMM_GEN_J 3'b100
`endif
`ifndef IMM_GEN_NONE
`define IMM_GEN_NONE 3'b111
`endif

module imm_dec_ctrl (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [`CPU_WIDTH-1:0]        if_inst,
    input  logic [`CPU_WIDTH-1:0]        if_pc,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [`CPU_WIDTH-1:0]        id_inst,
    output logic [`CPU_WIDTH-1:0]        id_pc,
    output logic [`IMM_GEN_OP_WIDTH-1:0] id_imm_gen_op,
    output logic                         id_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t                         r_state;
    logic                           r_if_ready;
    logic                           r_id_valid;
    logic [`CPU_WIDTH-1:0]          r_main_inst;
    logic [`CPU_WIDTH-1:0]          r_main_pc;
    logic [`IMM_GEN_OP_WIDTH-1:0]   r_main_op;
    logic [`CPU_WIDTH-1:0]          r_skid_inst;
    logic [`CPU_WIDTH-1:0]          r_skid_pc;
    logic [`IMM_GEN_OP_WIDTH-1:0]   r_skid_op;

    logic                           w_in_hs;
    logic                           w_out_hs;
    logic [`IMM_GEN_OP_WIDTH-1:0]   w_dec_op;
    logic                           w_known;

    assign w_in_hs  = if_valid & r_if_ready;
    assign w_out_hs = r_id_valid & id_ready;

    // Opcodes ending in anything but 2'b11 fall into the default arm.
    always_comb begin
        w_dec_op = `IMM_GEN_NONE;
        w_known  = 1'b1;
        case (if_inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR: w_dec_op = `IMM_GEN_I;
            OP_STORE:                 w_dec_op = `IMM_GEN_S;
            OP_BRANCH:                w_dec_op = `IMM_GEN_B;
            OP_JAL:                   w_dec_op = `IMM_GEN_J;
            OP_LUI, OP_AUIPC:         w_dec_op = `IMM_GEN_U;
            OP_REG, OP_FENCE,
            OP_SYSTEM:                w_dec_op = `IMM_GEN_NONE;
            default: begin
                w_dec_op = `IMM_GEN_NONE;
                w_known  = 1'b0;
            end
        endcase
    end

`ifdef ID_ILLEGAL_CHK_EN
    logic r_main_ill;
    logic r_skid_ill;
    logic w_dec_ill;

    assign w_dec_ill  = ~w_known | (if_inst[1:0] != 2'b11);
    assign id_illegal = r_main_ill;
`else
    logic w_unused;

    assign w_unused   = w_known;
    assign id_illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_if_ready  <= 1'b1;
            r_id_valid  <= 1'b0;
            r_main_inst <= '0;
            r_main_pc   <= '0;
            r_main_op   <= `IMM_GEN_NONE;
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
            r_skid_op   <= `IMM_GEN_NONE;
`ifdef ID_ILLEGAL_CHK_EN
            r_main_ill  <= 1'b0;
            r_skid_ill  <= 1'b0;
`endif
        end else if (flush) begin
            r_state    <= EMPTY;
            r_if_ready <= 1'b1;
            r_id_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_hs) begin
                        r_main_inst <= if_inst;
                        r_main_pc   <= if_pc;
                        r_main_op   <= w_dec_op;
`ifdef ID_ILLEGAL_CHK_EN
                        r_main_ill  <= w_dec_ill;
`endif
                        r_state     <= ONE;
                        r_id_valid  <= 1'b1;
                    end
                end
                ONE: begin
                    unique case ({w_in_hs, w_out_hs})
                        2'b10: begin
                            r_skid_inst <= if_inst;
                            r_skid_pc   <= if_pc;
                            r_skid_op   <= w_dec_op;
`ifdef ID_ILLEGAL_CHK_EN
                            r_skid_ill  <= w_dec_ill;
`endif
                            r_state     <= FULL;
                            r_if_ready  <= 1'b0;
                        end
                        2'b01: begin
                            r_state    <= EMPTY;
                            r_id_valid <= 1'b0;
                        end
                        2'b11: begin
                            r_main_inst <= if_inst;
                            r_main_pc   <= if_pc;
                            r_main_op   <= w_dec_op;
`ifdef ID_ILLEGAL_CHK_EN
                            r_main_ill  <= w_dec_ill;
`endif
                        end
                        default: begin
                        end
                    endcase
                end
                FULL: begin
                    // if_ready is low here, so only the drain side can move
                    if (w_out_hs) begin
                        r_main_inst <= r_skid_inst;
                        r_main_pc   <= r_skid_pc;
                        r_main_op   <= r_skid_op;
`ifdef ID_ILLEGAL_CHK_EN
                        r_main_ill  <= r_skid_ill;
`endif
                        r_state     <= ONE;
                        r_if_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_if_ready <= 1'b1;
                    r_id_valid <= 1'b0;
                end
            endcase
        end
    end

    assign if_ready      = r_if_ready;
    assign id_valid      = r_id_valid;
    assign id_inst       = r_main_inst;
    assign id_pc         = r_main_pc;
    assign id_imm_gen_op = r_main_op;

endmodule

// File: tb/tb_imm_dec_ctrl.sv
// Scoreboard bench for imm_dec_ctrl: expected beats queued on accept,
// compared on consume; flush and reset empty the queue.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef IMM_GEN_OP_WIDTH
`define IMM_GEN_OP_WIDTH 3
`endif
`ifndef IMM_GEN_I
`define IMM_GEN_I 3'b000
`endif
`ifndef IMM_GEN_S
`define IMM_GEN_S 3'b001
`endif
`ifndef IMM_GEN_B
`define IMM_GEN_B 3'b010
`endif
`ifndef IMM_GEN_U
`define IMM_GEN_U 3'b011
`endif
`ifndef IMM_GEN_J
`define IMM_GEN_J 3'b100
`endif
`ifndef IMM_GEN_NONE
`define IMM_GEN_NONE 3'b111
`endif

module tb_imm_dec_ctrl;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         flush;
    logic                         if_valid;
    logic                         if_ready;
    logic [`CPU_WIDTH-1:0]        if_inst;
    logic [`CPU_WIDTH-1:0]        if_pc;
    logic                         id_valid;
    logic                         id_ready;
    logic [`CPU_WIDTH-1:0]        id_inst;
    logic [`CPU_WIDTH-1:0]        id_pc;
    logic [`IMM_GEN_OP_WIDTH-1:0] id_imm_gen_op;
    logic                         id_illegal;

    typedef struct {
        logic [`CPU_WIDTH-1:0]        inst;
        logic [`CPU_WIDTH-1:0]        pc;
        logic [`IMM_GEN_OP_WIDTH-1:0] op;
        logic                         ill;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pop   = 0;

    imm_dec_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_imm_gen_op (id_imm_gen_op),
        .id_illegal    (id_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_op(input logic [31:0] inst);
        logic [6:0] o;
        o = inst[6:0];
        if (o == 7'h03 || o == 7'h13 || o == 7'h67) return `IMM_GEN_I;
        if (o == 7'h23) return `IMM_GEN_S;
        if (o == 7'h63) return `IMM_GEN_B;
        if (o == 7'h6F) return `IMM_GEN_J;
        if (o == 7'h37 || o == 7'h17) return `IMM_GEN_U;
        return `IMM_GEN_NONE;
    endfunction

    function automatic logic ref_ill(input logic [31:0] inst);
`ifdef ID_ILLEGAL_CHK_EN
        logic [6:0] o;
        o = inst[6:0];
        return !(o == 7'h03 || o == 7'h13 || o == 7'h67 || o == 7'h23 ||
                 o == 7'h63 || o == 7'h6F || o == 7'h37 || o == 7'h17 ||
                 o == 7'h33 || o == 7'h0F || o == 7'h73);
`else
        return 1'b0 & inst[0];
`endif
    endfunction

    // Inputs are set at the negedge by the caller; one clock is consumed.
    task automatic step();
        bit   in_hs;
        bit   out_hs;
        exp_t e;
        in_hs  = if_valid && if_ready;
        out_hs = id_valid && id_ready;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_hs) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(id_inst), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    chk("out_inst", 64'(id_inst), 64'(e.inst));
                    chk("out_pc", 64'(id_pc), 64'(e.pc));
                    chk("out_op", 64'(id_imm_gen_op), 64'(e.op));
                    chk("out_ill", 64'(id_illegal), 64'(e.ill));
                end
            end
            if (in_hs) begin
                e.inst = if_inst;
                e.pc   = if_pc;
                e.op   = ref_op(if_inst);
                e.ill  = ref_ill(if_inst);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] inst,
                         input logic [31:0] pc);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    logic [31:0] stream[8];
    int          pops0;

    initial begin
        stream = '{32'h000120B7, 32'h00001117, 32'h00008067, 32'h0000A183,
                   32'h002081B3, 32'h0000000F, 32'h00000073, 32'hFE000EE3};
        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 64'(id_valid), 64'd0);
        chk("rst_ready", 64'(if_ready), 64'd1);
        chk("rst_inst", 64'(id_inst), 64'd0);
        chk("rst_pc", 64'(id_pc), 64'd0);
        chk("rst_op", 64'(id_imm_gen_op), 64'(`IMM_GEN_NONE));
        chk("rst_ill", 64'(id_illegal), 64'd0);

        // basic addi pass
        id_ready = 1'b1;
        drive(1'b1, 32'h00500093, 32'h100);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("basic_valid", 64'(id_valid), 64'd1);
        chk("basic_op", 64'(id_imm_gen_op), 64'(`IMM_GEN_I));
        step();
        chk("basic_drain", 64'(id_valid), 64'd0);

        // skid fill
        id_ready = 1'b0;
        drive(1'b1, 32'h00112623, 32'h104);
        step();
        chk("skid_rdy1", 64'(if_ready), 64'd1);
        drive(1'b1, 32'h00208463, 32'h108);
        step();
        chk("skid_full", 64'(if_ready), 64'd0);
        drive(1'b1, 32'h008000EF, 32'h10C);
        step();
        chk("skid_hold_rdy", 64'(if_ready), 64'd0);
        chk("skid_hold_op", 64'(id_imm_gen_op), 64'(`IMM_GEN_S));
        id_ready = 1'b1;
        step();
        chk("skid_op_b", 64'(id_imm_gen_op), 64'(`IMM_GEN_B));
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("skid_op_j", 64'(id_imm_gen_op), 64'(`IMM_GEN_J));
        step();
        chk("skid_empty", 64'(id_valid), 64'd0);

        // steady stream
        pops0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, stream[i], 32'h200 + 32'(4 * i));
            chk("strm_rdy", 64'(if_ready), 64'd1);
            step();
            chk("strm_valid", 64'(id_valid), 64'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("strm_count", 64'(n_pop - pops0), 64'd8);

        // flush in FULL with input offered and id_ready high
        id_ready = 1'b0;
        drive(1'b1, 32'h00000013, 32'h300);
        step();
        drive(1'b1, 32'h00100013, 32'h304);
        step();
        chk("fl_full", 64'(if_ready), 64'd0);
        flush = 1'b1; id_ready = 1'b1;
        drive(1'b1, 32'h00200013, 32'h308);
        step();
        flush = 1'b0;
        chk("fl_valid", 64'(id_valid), 64'd0);
        chk("fl_ready", 64'(if_ready), 64'd1);
        // flush in ONE while a beat is accepted
        id_ready = 1'b0;
        drive(1'b1, 32'h00300013, 32'h30C);
        step();
        flush = 1'b1; id_ready = 1'b1;
        drive(1'b1, 32'h00400013, 32'h310);
        step();
        flush = 1'b0;
        chk("fl1_valid", 64'(id_valid), 64'd0);
        chk("fl1_ready", 64'(if_ready), 64'd1);
        drive(1'b1, 32'h0000A023, 32'h314);
        step();
        chk("fl_marker", 64'(id_inst), 64'h0000A023);
        drive(1'b0, 32'h0, 32'h0);
        step();

        // illegal opcodes
        drive(1'b1, 32'h0000007F, 32'h400);
        step();
        drive(1'b1, 32'h00000010, 32'h404);
        chk("ill_op", 64'(id_imm_gen_op), 64'(`IMM_GEN_NONE));
`ifdef ID_ILLEGAL_CHK_EN
        chk("ill_flag", 64'(id_illegal), 64'd1);
`else
        chk("ill_flag", 64'(id_illegal), 64'd0);
`endif
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("ill_low2_op", 64'(id_imm_gen_op), 64'(`IMM_GEN_NONE));
        step();

        // reset while FULL
        id_ready = 1'b0;
        drive(1'b1, 32'h00112623, 32'h500);
        step();
        drive(1'b1, 32'h00208463, 32'h504);
        step();
        chk("rf_full", 64'(if_ready), 64'd0);
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("rf_valid", 64'(id_valid), 64'd0);
        chk("rf_ready", 64'(if_ready), 64'd1);
        chk("rf_inst", 64'(id_inst), 64'd0);
        chk("rf_op", 64'(id_imm_gen_op), 64'(`IMM_GEN_NONE));
        id_ready = 1'b1;
        step();
        chk("rf_stay", 64'(id_valid), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
